// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame buffer geometry and pixel colour type for the
// SPI-fed VGA frame buffer.
package vga_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned H_FP        = 16;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BP        = 48;
  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned V_FP        = 10;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BP        = 33;
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CLK_PER_PIX = 4;
  localparam int unsigned FB_SIZE     = H_ACTIVE * V_ACTIVE;
  localparam int unsigned ADDR_W      = 19;

  typedef logic [5:0] color_t;

  // Half-open window test [lo, hi) on a 10-bit counter.
  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/spi_rx_byte.sv
// SPI mode-0 slave receiver, MSB first: synchronizes Sclk/Mosi/CSel into the system clock,
// shifts on Sclk rising edges and pulses byte_valid for one clock per completed byte.
module spi_rx_byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       csel,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  // Third Sclk stage gives the edge detector; Mosi stays aligned with Sclk stage 1.
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] csel_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] data_d;
  logic       valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q     <= '0;
      mosi_q     <= '0;
      csel_q     <= 2'b11;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], sclk};
      mosi_q     <= {mosi_q[0], mosi};
      csel_q     <= {csel_q[0], csel};
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_data  <= data_d;
      byte_valid <= valid_d;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = byte_data;
    valid_d   = 1'b0;
    if (csel_q[1]) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sclk_q[1] && !sclk_q[2]) begin
      shift_d   = {shift_q[5:0], mosi_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        valid_d = 1'b1;
        data_d  = {shift_q, mosi_q[1]};
      end
    end
  end

endmodule

// File: rtl/vga_spi_framebuffer.sv
// 640x480@60 VGA scan-out from an 8-bit async SRAM, with SPI-fed pixel writes interleaved
// into the second half of each pixel slot. Define VGA_SYNC_POS_EN for active-high syncs.
module vga_spi_framebuffer
  import vga_pkg::*;
(
  input  logic        MainClkSrc,
  input  logic        Reset,
  output logic [18:0] MemAddr,
  inout  wire  [7:0]  MemData,
  output logic        MemWE,
  output logic        MemOE,
  output logic [5:0]  ColorOut,
  output logic        HsyncOut,
  output logic        VsyncOut,
  input  logic        Sclk,
  input  logic        Mosi,
  input  logic        CSel
);

`ifdef VGA_SYNC_POS_EN
  localparam logic sync_idle = 1'b0;
`else
  localparam logic sync_idle = 1'b1;
`endif
  localparam logic [1:0] last_phase = 2'(CLK_PER_PIX - 1);

  logic [1:0]        phase_q, phase_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] disp_q, disp_d, wr_ptr_q, wr_ptr_d, addr_d;
  logic              pending_q, pending_d, wr_slot_q, wr_slot_d;
  logic [7:0]        hold_q, hold_d, wr_data_q, wr_data_d;
  logic [5:0]        rd_data_q;
  logic              oe_n_d, we_n_d;
  color_t            color_q;
  logic              hs_q, vs_q;
  logic              pix_end, active_cur, active_nxt, hs_on, vs_on;
  logic [7:0]        rx_byte;
  logic              rx_valid;

  spi_rx_byte u_spi_rx (
    .clk        (MainClkSrc),
    .rst        (Reset),
    .sclk       (Sclk),
    .mosi       (Mosi),
    .csel       (CSel),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid)
  );

  assign pix_end    = (phase_q == last_phase);
  assign phase_d    = phase_q + 2'd1;
  assign active_cur = in_range(x_q, '0, 10'(H_ACTIVE)) && in_range(y_q, '0, 10'(V_ACTIVE));
  assign active_nxt = in_range(x_d, '0, 10'(H_ACTIVE)) && in_range(y_d, '0, 10'(V_ACTIVE));
  assign hs_on      = in_range(x_q, 10'(H_ACTIVE + H_FP), 10'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on      = in_range(y_q, 10'(V_ACTIVE + V_FP), 10'(V_ACTIVE + V_FP + V_SYNC));

  // Display address counts active pixels, which equals y*640+x without a multiplier.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    disp_d = disp_q;
    if (pix_end) begin
      if (active_cur) disp_d = disp_q + 19'd1;
      if (x_q == 10'(H_TOTAL - 1)) begin
        x_d = '0;
        if (y_q == 10'(V_TOTAL - 1)) begin
          y_d    = '0;
          disp_d = '0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Write decision and data are frozen at the read/write boundary for the whole slot.
  always_comb begin
    wr_slot_d = wr_slot_q;
    wr_data_d = wr_data_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    wr_ptr_d  = wr_ptr_q;
    if (phase_q == 2'd1) begin
      wr_slot_d = pending_q;
      wr_data_d = hold_q;
    end else if (pix_end) begin
      wr_slot_d = 1'b0;
    end
    if (rx_valid) begin
      pending_d = 1'b1;
      hold_d    = rx_byte;
    end else if (pix_end && wr_slot_q) begin
      pending_d = 1'b0;
    end
    if (pix_end && wr_slot_q) begin
      wr_ptr_d = (wr_ptr_q == 19'(FB_SIZE - 1)) ? '0 : wr_ptr_q + 19'd1;
    end
    // SRAM strobes are registered from next-state so they never glitch.
    oe_n_d = !(!phase_d[1] && active_nxt);
    we_n_d = !(phase_d[1] && wr_slot_d);
    addr_d = phase_d[1] ? wr_ptr_q : disp_d;
  end

  always_ff @(posedge MainClkSrc or posedge Reset) begin
    if (Reset) begin
      phase_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      disp_q    <= '0;
      wr_ptr_q  <= '0;
      pending_q <= 1'b0;
      wr_slot_q <= 1'b0;
      hold_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      MemOE     <= 1'b1;
      MemWE     <= 1'b1;
      MemAddr   <= '0;
      color_q   <= '0;
      hs_q      <= sync_idle;
      vs_q      <= sync_idle;
    end else begin
      phase_q   <= phase_d;
      x_q       <= x_d;
      y_q       <= y_d;
      disp_q    <= disp_d;
      wr_ptr_q  <= wr_ptr_d;
      pending_q <= pending_d;
      wr_slot_q <= wr_slot_d;
      hold_q    <= hold_d;
      wr_data_q <= wr_data_d;
      MemOE     <= oe_n_d;
      MemWE     <= we_n_d;
      MemAddr   <= addr_d;
      if (phase_q == 2'd1 && !MemOE) rd_data_q <= MemData[7:2];
      if (pix_end) begin
        color_q <= active_cur ? rd_data_q : '0;
        hs_q    <= hs_on ? !sync_idle : sync_idle;
        vs_q    <= vs_on ? !sync_idle : sync_idle;
      end
    end
  end

  assign MemData  = MemWE ? 8'bz : wr_data_q;
  assign ColorOut = color_q;
  assign HsyncOut = hs_q;
  assign VsyncOut = vs_q;

endmodule

// File: tb/tb_vga_spi_framebuffer.sv
// Scoreboard bench: SPI stimulus pushes expected SRAM writes; monitors check writes and
// compare video/SRAM-read behaviour against a time-indexed raster model.
module tb_vga_spi_framebuffer;

`ifdef VGA_SYNC_POS_EN
  localparam logic sync_idle = 1'b0;
`else
  localparam logic sync_idle = 1'b1;
`endif
  localparam int fb_size   = 307200;
  localparam int vid_lines = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        mem_we, mem_oe;
  logic [5:0]  color;
  logic        hsync, vsync;
  logic        sclk, mosi, csel;

  logic [7:0]  mem [0:524287];
  int          tests = 0, fails = 0;
  int          cyc = 0;
  logic        vid_en = 1'b0;
  int          ptr_model = 0;
  logic [26:0] exp_q [$];

  always #5 clk = ~clk;

  vga_spi_framebuffer dut (
    .MainClkSrc (clk),
    .Reset      (rst),
    .MemAddr    (mem_addr),
    .MemData    (mem_data),
    .MemWE      (mem_we),
    .MemOE      (mem_oe),
    .ColorOut   (color),
    .HsyncOut   (hsync),
    .VsyncOut   (vsync),
    .Sclk       (sclk),
    .Mosi       (mosi),
    .CSel       (csel)
  );

  // Async SRAM model: drives only during a read with WE high.
  assign mem_data = (!mem_oe && mem_we) ? mem[mem_addr] : 8'bz;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_color"}, color, 0);
    check({tag, "_hsync"}, hsync, sync_idle);
    check({tag, "_vsync"}, vsync, sync_idle);
    check({tag, "_we"}, mem_we, 1);
    check({tag, "_oe"}, mem_oe, 1);
  endtask

  // Sends nbits of b MSB first; only a complete byte is expected to reach the SRAM.
  task automatic spi_send(input logic [7:0] b, input int nbits, input int half);
    if (nbits == 8) begin
      exp_q.push_back({19'(ptr_model), b});
      ptr_model = (ptr_model + 1) % fb_size;
    end
    @(posedge clk);
    #2;
    csel = 1'b0;
    #20;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      sclk = 1'b0;
      #(half * 10);
      sclk = 1'b1;
      #(half * 10);
    end
    sclk = 1'b0;
    #(half * 10);
    csel = 1'b1;
    #40;
  endtask

  task automatic drain_writes();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("writes_drained", exp_q.size(), 0);
  endtask

  // Write monitor: pops the scoreboard at the first low cycle of each WE pulse.
  initial begin : write_mon
    int we_len;
    logic [26:0] e;
    we_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_len = 0;
      end else if (!mem_we) begin
        check("oe_high_during_write", mem_oe, 1);
        if (we_len == 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write_addr", mem_addr, 0);
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", mem_addr, e[26:8]);
            check("write_data", mem_data, e[7:0]);
            check("write_phase", cyc % 4, 2);
          end
          mem[mem_addr] = mem_data;
        end
        we_len++;
      end else if (we_len != 0) begin
        check("we_low_clocks", we_len, 2);
        we_len = 0;
      end
    end
  end

  // Raster model: after c clocks the slot is pixel c/4, phase c%4; outputs lag one pixel.
  initial begin : video_mon
    int c, p, ph, x, y, pp, px, py, last_fall;
    logic act, pact, hs_prev;
    last_fall = -1;
    hs_prev   = sync_idle;
    forever begin
      @(negedge clk);
      if (vid_en && !rst && cyc >= 1) begin
        c   = cyc;
        p   = c / 4;
        ph  = c % 4;
        x   = p % 800;
        y   = p / 800;
        act = (x < 640) && (y < 480);
        check("read_oe", mem_oe, !(ph < 2 && act));
        if (!mem_oe) check("read_addr", mem_addr, y * 640 + x);
        if (ph == 2) begin
          if (p == 0) begin
            check("early_color", color, 0);
            check("early_hsync", hsync, sync_idle);
          end else begin
            pp   = p - 1;
            px   = pp % 800;
            py   = pp / 800;
            pact = (px < 640) && (py < 480);
            check("color", color, pact ? longint'(mem[py * 640 + px][7:2]) : 0);
            check("hsync", hsync, (px >= 656 && px < 752) ? !sync_idle : sync_idle);
            check("vsync", vsync, (py >= 490 && py < 492) ? !sync_idle : sync_idle);
          end
        end
        if (hsync != hs_prev) begin
          if (hsync != sync_idle) begin
            if (last_fall >= 0) check("hsync_period", c - last_fall, 3200);
            last_fall = c;
          end else if (last_fall >= 0) begin
            check("hsync_width", c - last_fall, 384);
          end
        end
        hs_prev = hsync;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    csel = 1'b1;
    for (int i = 0; i < 524288; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hC0;
    #95;
    check_reset_outputs("reset");
    #7;
    rst    = 1'b0;
    vid_en = 1'b1;

    // Line 0 is fully read before any write lands in addresses 0..N.
    while (cyc < 2800) @(posedge clk);
    repeat (3) spi_send(8'hC0, 8, 1);
    repeat (3) spi_send(8'h03, 8, 1);
    drain_writes();
    spi_send(8'($urandom), 5, 1);
    spi_send(8'hA5, 8, 1);
    for (int i = 0; i < 8; i++) spi_send(8'($urandom), 8, int'($urandom_range(1, 3)));
    drain_writes();

    while (cyc < vid_lines * 3200) @(posedge clk);
    vid_en = 1'b0;

    // Reset in the middle of a byte: partial bits and pointer are discarded.
    @(posedge clk);
    #2;
    csel = 1'b0;
    #20;
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      sclk = 1'b0;
      #10;
      sclk = 1'b1;
      #10;
    end
    rst = 1'b1;
    #30;
    check_reset_outputs("midreset");
    sclk = 1'b0;
    csel = 1'b1;
    #20;
    rst       = 1'b0;
    ptr_model = 0;
    spi_send(8'h5A, 8, 1);
    spi_send(8'h3C, 8, 2);
    drain_writes();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
